// File: rtl/riscv_ctrl_pkg.sv
// Shared RISC-V control definitions: opcode classes, sequencer state encodings,
// ALUOp codes and the control-line bundle driven by the multi-cycle sequencer.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_RFN  = 2'b10;
  localparam logic [1:0] ALUOP_IFN  = 2'b11;

  typedef struct packed {
    logic legal;
    logic is_r;
    logic is_i;
    logic is_ld;
    logic is_st;
    logic is_br;
  } opclass_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier: maps instr[6:0] onto one-hot class flags
// plus a legal flag covering every supported class.
module opcode_class_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   cls
);

  always_comb begin
    cls = '0;
    case (opcode)
      OPC_R:      cls.is_r  = 1'b1;
      OPC_I:      cls.is_i  = 1'b1;
      OPC_LOAD:   cls.is_ld = 1'b1;
      OPC_STORE:  cls.is_st = 1'b1;
      OPC_BRANCH: cls.is_br = 1'b1;
      default:    ;
    endcase
    cls.legal = cls.is_r | cls.is_i | cls.is_ld | cls.is_st | cls.is_br;
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RISC-V control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// ready handshake, datapath control decode and a retired-instruction counter.
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             branch,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             illegal_op,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q;
  state_t           state_d;
  logic [6:0]       opcode_q;
  logic [6:0]       dec_opcode;
  logic [CNT_W-1:0] instret_q;
  opclass_t         cls;
  ctrl_t            ctrl_c;
  ctrl_t            ctrl_o;
  logic             retire;

  // DECODE classifies the live IR opcode; later states use the captured copy,
  // so one decoder serves both.
  assign dec_opcode = (state_q == ST_DECODE) ? opcode : opcode_q;

  opcode_class_decode u_decode (
    .opcode (dec_opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      opcode_q  <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        opcode_q <= opcode;
      end
      if (retire) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ctrl_c.mem_read = 1'b1;
        if (mem_ready) begin
          ctrl_c.ir_write = 1'b1;
          ctrl_c.pc_write = 1'b1;
          state_d         = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls.legal) begin
          state_d = ST_EXEC;
        end else begin
          ctrl_c.illegal_op = 1'b1;
          state_d           = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (cls.is_r) begin
          ctrl_c.alu_op = ALUOP_RFN;
          state_d       = ST_WB;
        end else if (cls.is_i) begin
          ctrl_c.alu_src = 1'b1;
          ctrl_c.alu_op  = ALUOP_IFN;
          state_d        = ST_WB;
        end else if (cls.is_ld || cls.is_st) begin
          ctrl_c.alu_src = 1'b1;
          ctrl_c.alu_op  = ALUOP_ADD;
          state_d        = ST_MEM;
        end else if (cls.is_br) begin
          ctrl_c.alu_op = ALUOP_SUB;
          ctrl_c.branch = 1'b1;
          state_d       = ST_FETCH;
          retire        = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (cls.is_ld) begin
          ctrl_c.mem_read = 1'b1;
          ctrl_c.alu_op   = ALUOP_ADD;
          if (mem_ready) begin
            state_d = ST_WB;
          end
        end else if (cls.is_st) begin
          ctrl_c.mem_write = 1'b1;
          if (mem_ready) begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = cls.is_ld;
        state_d           = ST_FETCH;
        retire            = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Reset blanks the strobes combinationally so FETCH's mem_read never shows
  // while reset is held.
  assign ctrl_o = reset ? '0 : ctrl_c;

  assign pc_write   = ctrl_o.pc_write;
  assign ir_write   = ctrl_o.ir_write;
  assign branch     = ctrl_o.branch;
  assign mem_read   = ctrl_o.mem_read;
  assign mem_write  = ctrl_o.mem_write;
  assign mem_to_reg = ctrl_o.mem_to_reg;
  assign alu_src    = ctrl_o.alu_src;
  assign alu_op     = ctrl_o.alu_op;
  assign reg_write  = ctrl_o.reg_write;
  assign illegal_op = ctrl_o.illegal_op;
  assign state      = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed per-cycle expectations
// are queued by the stimulus and popped/compared by a negedge monitor.
module tb_multicycle_control_fsm;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam logic [6:0] JUNK  = 7'b1111111;

  // {pc_write, ir_write, branch, mem_read, mem_write, mem_to_reg, alu_src, alu_op[1:0], reg_write, illegal_op}
  localparam logic [10:0] C_PCW  = 11'h400;
  localparam logic [10:0] C_IRW  = 11'h200;
  localparam logic [10:0] C_BR   = 11'h100;
  localparam logic [10:0] C_MRD  = 11'h080;
  localparam logic [10:0] C_MW   = 11'h040;
  localparam logic [10:0] C_M2R  = 11'h020;
  localparam logic [10:0] C_ASRC = 11'h010;
  localparam logic [10:0] C_AOPR = 11'h008;
  localparam logic [10:0] C_AOPI = 11'h00C;
  localparam logic [10:0] C_AOPS = 11'h004;
  localparam logic [10:0] C_RW   = 11'h002;
  localparam logic [10:0] C_ILL  = 11'h001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = '0;
  logic        mem_ready = 1'b0;

  logic        pc_write, ir_write, branch, mem_read, mem_write, mem_to_reg, alu_src, reg_write, illegal_op;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] instret;

  logic        pc_write4, ir_write4, branch4, mem_read4, mem_write4, mem_to_reg4, alu_src4, reg_write4, illegal_op4;
  logic [1:0]  alu_op4;
  logic [2:0]  state4;
  logic [3:0]  instret4;

  logic [10:0] act_ctl, act_ctl4;
  assign act_ctl  = {pc_write, ir_write, branch, mem_read, mem_write, mem_to_reg, alu_src, alu_op, reg_write, illegal_op};
  assign act_ctl4 = {pc_write4, ir_write4, branch4, mem_read4, mem_write4, mem_to_reg4, alu_src4, alu_op4, reg_write4, illegal_op4};

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .branch(branch), .mem_read(mem_read),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op),
    .reg_write(reg_write), .illegal_op(illegal_op), .state(state), .instret(instret)
  );

  multicycle_control_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write4), .ir_write(ir_write4), .branch(branch4), .mem_read(mem_read4),
    .mem_write(mem_write4), .mem_to_reg(mem_to_reg4), .alu_src(alu_src4), .alu_op(alu_op4),
    .reg_write(reg_write4), .illegal_op(illegal_op4), .state(state4), .instret(instret4)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [10:0] ctl;
    int unsigned ir;
  } exp_t;

  exp_t        sb[$];
  exp_t        m;
  int          checks = 0;
  int          failures = 0;
  int unsigned exp_ir = 0;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      m = sb.pop_front();
      checks++;
      if ({state, act_ctl} !== {m.st, m.ctl}) begin
        failures++;
        $display("FAIL %s ctl: got state=%0d ctl=%b, want state=%0d ctl=%b", m.name, state, act_ctl, m.st, m.ctl);
      end
      checks++;
      if (instret !== m.ir) begin
        failures++;
        $display("FAIL %s instret: got %0d, want %0d", m.name, instret, m.ir);
      end
      checks++;
      if ({state4, act_ctl4} !== {m.st, m.ctl}) begin
        failures++;
        $display("FAIL %s ctl_w4: got state=%0d ctl=%b, want state=%0d ctl=%b", m.name, state4, act_ctl4, m.st, m.ctl);
      end
      checks++;
      if (instret4 !== 4'(m.ir)) begin
        failures++;
        $display("FAIL %s instret_w4: got %0d, want %0d", m.name, instret4, 4'(m.ir));
      end
    end
  end

  task automatic cyc(input string nm, input logic r, input logic [6:0] opc, input logic mrdy,
                     input logic [2:0] st, input logic [10:0] ctl);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = r;
    opcode    = opc;
    mem_ready = mrdy;
    if (r) exp_ir = 0;
    e.name = nm;
    e.st   = st;
    e.ctl  = ctl;
    e.ir   = exp_ir;
    sb.push_back(e);
  endtask

  task automatic fetch(input int unsigned waits);
    for (int unsigned i = 0; i < waits; i++) cyc("fetch_wait", 1'b0, JUNK, 1'b0, 3'd0, C_MRD);
    cyc("fetch", 1'b0, JUNK, 1'b1, 3'd0, C_MRD | C_IRW | C_PCW);
  endtask

  task automatic run_alu(input logic [6:0] opc, input logic [10:0] exec_ctl, input int unsigned fw);
    fetch(fw);
    cyc("alu_decode", 1'b0, opc, 1'b1, 3'd1, '0);
    cyc("alu_exec", 1'b0, JUNK, 1'b1, 3'd2, exec_ctl);
    cyc("alu_wb", 1'b0, LD_OP, 1'b1, 3'd4, C_RW);
    exp_ir++;
  endtask

  task automatic run_load(input int unsigned fw, input int unsigned mw);
    fetch(fw);
    cyc("ld_decode", 1'b0, LD_OP, 1'b1, 3'd1, '0);
    cyc("ld_exec", 1'b0, JUNK, 1'b1, 3'd2, C_ASRC);
    for (int unsigned i = 0; i < mw; i++) cyc("ld_mem_wait", 1'b0, R_OP, 1'b0, 3'd3, C_MRD);
    cyc("ld_mem", 1'b0, JUNK, 1'b1, 3'd3, C_MRD);
    cyc("ld_wb", 1'b0, JUNK, 1'b1, 3'd4, C_RW | C_M2R);
    exp_ir++;
  endtask

  task automatic run_store(input int unsigned fw, input int unsigned mw);
    fetch(fw);
    cyc("st_decode", 1'b0, ST_OP, 1'b1, 3'd1, '0);
    cyc("st_exec", 1'b0, JUNK, 1'b1, 3'd2, C_ASRC);
    for (int unsigned i = 0; i < mw; i++) cyc("st_mem_wait", 1'b0, JUNK, 1'b0, 3'd3, C_MW);
    cyc("st_mem", 1'b0, JUNK, 1'b1, 3'd3, C_MW);
    exp_ir++;
  endtask

  task automatic run_branch();
    fetch(0);
    cyc("br_decode", 1'b0, BR_OP, 1'b1, 3'd1, '0);
    cyc("br_exec", 1'b0, JUNK, 1'b1, 3'd2, C_BR | C_AOPS);
    exp_ir++;
  endtask

  initial begin
    // mem_ready high alongside reset: reset must win
    cyc("reset", 1'b1, R_OP, 1'b1, 3'd0, '0);
    run_alu(R_OP, C_AOPR, 0);
    run_load(0, 3);
    run_store(1, 2);
    run_branch();
    fetch(0);
    cyc("ill_decode", 1'b0, JUNK, 1'b1, 3'd1, C_ILL);
    run_alu(I_OP, C_ASRC | C_AOPI, 0);
    // abort a load mid-MEM
    fetch(0);
    cyc("ld_decode", 1'b0, LD_OP, 1'b1, 3'd1, '0);
    cyc("ld_exec", 1'b0, JUNK, 1'b1, 3'd2, C_ASRC);
    cyc("ld_mem_wait", 1'b0, JUNK, 1'b0, 3'd3, C_MRD);
    cyc("rst_mid", 1'b1, JUNK, 1'b1, 3'd0, '0);
    cyc("rst_hold", 1'b1, JUNK, 1'b1, 3'd0, '0);
    cyc("post_rst", 1'b0, JUNK, 1'b0, 3'd0, C_MRD);
    // 16 retires: narrow counter passes 15 and wraps to 0
    for (int unsigned k = 0; k < 16; k++) begin
      if (k[0]) run_alu(I_OP, C_ASRC | C_AOPI, 0);
      else      run_alu(R_OP, C_AOPR, 0);
    end
    cyc("idle_fetch", 1'b0, JUNK, 1'b0, 3'd0, C_MRD);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
